// File: rtl/router_crossbar_arbiter.sv
// Switch allocator for one mesh router node: XY route decode, per-output round-robin
// arbitration, registered read/write strobes and packet data, saturating drop counter.
module router_crossbar_arbiter #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  Clk_r,
  input  logic                  Rst,
  input  logic [7:0]            Router_Address,
  input  logic [3:0]            Link_Config,
  input  logic [31:0]           Packet_From_Link_N,
  input  logic [31:0]           Packet_From_Link_S,
  input  logic [31:0]           Packet_From_Link_W,
  input  logic [31:0]           Packet_From_Link_E,
  input  logic [31:0]           Packet_From_Node,
  input  logic                  RxQueue_Empty_N,
  input  logic                  RxQueue_Empty_S,
  input  logic                  RxQueue_Empty_W,
  input  logic                  RxQueue_Empty_E,
  input  logic                  Node_Queue_Empty,
  input  logic                  TxQueue_Full_N,
  input  logic                  TxQueue_Full_S,
  input  logic                  TxQueue_Full_W,
  input  logic                  TxQueue_Full_E,
  output logic [31:0]           Packet_To_Link_N,
  output logic [31:0]           Packet_To_Link_S,
  output logic [31:0]           Packet_To_Link_W,
  output logic [31:0]           Packet_To_Link_E,
  output logic [31:0]           Packet_To_Node,
  output logic                  TxQueue_Write_N,
  output logic                  TxQueue_Write_S,
  output logic                  TxQueue_Write_W,
  output logic                  TxQueue_Write_E,
  output logic                  Node_Write,
  output logic                  RxQueue_Read_N,
  output logic                  RxQueue_Read_S,
  output logic                  RxQueue_Read_W,
  output logic                  RxQueue_Read_E,
  output logic                  Node_Read,
  output logic [DROP_CNT_W-1:0] Drop_Count
);

  localparam int unsigned NP = 5;
  localparam int unsigned PW = 32;
  localparam logic [2:0]  OUT_N = 3'd0;
  localparam logic [2:0]  OUT_S = 3'd1;
  localparam logic [2:0]  OUT_W = 3'd2;
  localparam logic [2:0]  OUT_E = 3'd3;
  localparam logic [2:0]  OUT_L = 3'd4;

  logic [PW-1:0]         head [NP];
  logic [NP-1:0]         empty, full, link_en;
  logic [2:0]            route [NP];
  logic [NP-1:0]         req, drop;
  logic [NP-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [2:0]            ptr_q [NP];
  logic [2:0]            ptr_d [NP];
  logic [PW-1:0]         pkt_q [NP];
  logic [PW-1:0]         pkt_d [NP];
  logic [DROP_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            idx;

  // Round-robin candidate k steps after the last granted input, modulo 5.
  function automatic logic [2:0] rr_idx(input logic [2:0] ptr, input int unsigned k);
    int unsigned s;
    s = 32'(ptr) + k;
    return 3'(s % NP);
  endfunction

  assign head[0] = Packet_From_Link_N;
  assign head[1] = Packet_From_Link_S;
  assign head[2] = Packet_From_Link_W;
  assign head[3] = Packet_From_Link_E;
  assign head[4] = Packet_From_Node;
  assign empty   = {Node_Queue_Empty, RxQueue_Empty_E, RxQueue_Empty_W, RxQueue_Empty_S, RxQueue_Empty_N};
  assign full    = {1'b0, TxQueue_Full_E, TxQueue_Full_W, TxQueue_Full_S, TxQueue_Full_N};
  assign link_en = {1'b1, Link_Config};

  // XY dimension-order route decode; inputs with a pending pop are masked.
  always_comb begin
    req  = ~empty & ~rd_q;
    drop = '0;
    for (int i = 0; i < NP; i++) begin
      if (head[i][31:28] > Router_Address[7:4])      route[i] = OUT_E;
      else if (head[i][31:28] < Router_Address[7:4]) route[i] = OUT_W;
      else if (head[i][27:24] > Router_Address[3:0]) route[i] = OUT_N;
      else if (head[i][27:24] < Router_Address[3:0]) route[i] = OUT_S;
      else                                           route[i] = OUT_L;
      drop[i] = req[i] && !link_en[route[i]];
    end
  end

  // Drops pop without arbitration; each eligible output grants its first requester.
  always_comb begin
    wr_d  = '0;
    rd_d  = '0;
    cnt_d = cnt_q;
    idx   = '0;
    for (int o = 0; o < NP; o++) begin
      ptr_d[o] = ptr_q[o];
      pkt_d[o] = pkt_q[o];
    end
    for (int i = 0; i < NP; i++) begin
      if (drop[i]) begin
        rd_d[i] = 1'b1;
        if (cnt_d != '1) cnt_d = cnt_d + DROP_CNT_W'(1);
      end
    end
    for (int o = 0; o < NP; o++) begin
      if (!full[o] && !wr_q[o]) begin
        for (int k = 1; k <= NP; k++) begin
          idx = rr_idx(ptr_q[o], 32'(k));
          if (!wr_d[o] && req[idx] && !drop[idx] && route[idx] == 3'(o)) begin
            wr_d[o]  = 1'b1;
            rd_d[idx] = 1'b1;
            ptr_d[o] = idx;
            pkt_d[o] = head[idx];
          end
        end
      end
    end
  end

  always_ff @(posedge Clk_r or posedge Rst) begin
    if (Rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int o = 0; o < NP; o++) begin
        ptr_q[o] <= 3'd4;
        pkt_q[o] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      for (int o = 0; o < NP; o++) begin
        ptr_q[o] <= ptr_d[o];
        pkt_q[o] <= pkt_d[o];
      end
    end
  end

  assign Packet_To_Link_N = pkt_q[0];
  assign Packet_To_Link_S = pkt_q[1];
  assign Packet_To_Link_W = pkt_q[2];
  assign Packet_To_Link_E = pkt_q[3];
  assign Packet_To_Node   = pkt_q[4];
  assign TxQueue_Write_N  = wr_q[0];
  assign TxQueue_Write_S  = wr_q[1];
  assign TxQueue_Write_W  = wr_q[2];
  assign TxQueue_Write_E  = wr_q[3];
  assign Node_Write       = wr_q[4];
  assign RxQueue_Read_N   = rd_q[0];
  assign RxQueue_Read_S   = rd_q[1];
  assign RxQueue_Read_W   = rd_q[2];
  assign RxQueue_Read_E   = rd_q[3];
  assign Node_Read        = rd_q[4];
  assign Drop_Count       = cnt_q;

endmodule

// File: tb/tb_router_crossbar_arbiter.sv
// Directed bench for router_crossbar_arbiter: behavioural input queues, write/read logs
// sampled on the falling edge, hand-computed expectations for node address 0x33.
module tb_router_crossbar_arbiter;

  logic        Clk_r = 1'b0;
  logic        Rst   = 1'b0;
  logic [7:0]  router_addr;
  logic [3:0]  link_cfg;
  logic [31:0] head [5];
  logic [4:0]  empty;
  logic [3:0]  full;
  logic [31:0] pkt_out [5];
  logic [4:0]  wr, rd;
  logic [7:0]  drop_cnt;

  logic [31:0] qmem [5][$];
  int          cyc;
  int          wr_cnt [5];
  int          wr_cyc [5];
  int          wr_first_cyc [5];
  logic [31:0] wr_last [5];
  logic [31:0] wr_first [5];
  int          rd_cnt [5];
  int          rd_cyc [5];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          p;

  always #5 Clk_r = ~Clk_r;

  router_crossbar_arbiter #(.DROP_CNT_W(8)) dut (
    .Clk_r(Clk_r), .Rst(Rst), .Router_Address(router_addr), .Link_Config(link_cfg),
    .Packet_From_Link_N(head[0]), .Packet_From_Link_S(head[1]),
    .Packet_From_Link_W(head[2]), .Packet_From_Link_E(head[3]), .Packet_From_Node(head[4]),
    .RxQueue_Empty_N(empty[0]), .RxQueue_Empty_S(empty[1]), .RxQueue_Empty_W(empty[2]),
    .RxQueue_Empty_E(empty[3]), .Node_Queue_Empty(empty[4]),
    .TxQueue_Full_N(full[0]), .TxQueue_Full_S(full[1]), .TxQueue_Full_W(full[2]),
    .TxQueue_Full_E(full[3]),
    .Packet_To_Link_N(pkt_out[0]), .Packet_To_Link_S(pkt_out[1]), .Packet_To_Link_W(pkt_out[2]),
    .Packet_To_Link_E(pkt_out[3]), .Packet_To_Node(pkt_out[4]),
    .TxQueue_Write_N(wr[0]), .TxQueue_Write_S(wr[1]), .TxQueue_Write_W(wr[2]),
    .TxQueue_Write_E(wr[3]), .Node_Write(wr[4]),
    .RxQueue_Read_N(rd[0]), .RxQueue_Read_S(rd[1]), .RxQueue_Read_W(rd[2]),
    .RxQueue_Read_E(rd[3]), .Node_Read(rd[4]),
    .Drop_Count(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic refresh(input int i);
    empty[i] = (qmem[i].size() == 0);
    head[i]  = empty[i] ? 32'h0 : qmem[i][0];
  endtask

  task automatic push(input int i, input logic [31:0] w);
    qmem[i].push_back(w);
    refresh(i);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 5; i++) begin
      wr_cnt[i] = 0; wr_cyc[i] = -1; wr_first_cyc[i] = -1;
      wr_last[i] = '0; wr_first[i] = '0; rd_cnt[i] = 0; rd_cyc[i] = -1;
    end
  endtask

  // One cycle: log strobes seen mid-cycle and pop queues that were read.
  task automatic tick();
    @(negedge Clk_r);
    cyc++;
    for (int o = 0; o < 5; o++) begin
      if (wr[o]) begin
        if (wr_cnt[o] == 0) begin
          wr_first[o] = pkt_out[o];
          wr_first_cyc[o] = cyc;
        end
        wr_cnt[o]++;
        wr_last[o] = pkt_out[o];
        wr_cyc[o] = cyc;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (rd[i]) begin
        rd_cnt[i]++;
        rd_cyc[i] = cyc;
        if (qmem[i].size() != 0) qmem[i].delete(0);
        refresh(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    ticks(2);
    Rst = 1'b0;
  endtask

  function automatic int total_wr();
    int s = 0;
    for (int o = 0; o < 5; o++) s += wr_cnt[o];
    return s;
  endfunction

  function automatic int total_rd();
    int s = 0;
    for (int i = 0; i < 5; i++) s += rd_cnt[i];
    return s;
  endfunction

  initial begin
    cyc = 0;
    router_addr = 8'h33;
    link_cfg = 4'b1111;
    full = 4'b0000;
    for (int i = 0; i < 5; i++) refresh(i);
    clear_logs();

    #1 Rst = 1'b1;
    #1;
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_pkt_n", pkt_out[0], 32'h0);
    ticks(2);
    Rst = 1'b0;

    // Node packet to N, timing and exclusivity
    tick();
    clear_logs();
    p = cyc;
    push(4, 32'h3400DEAD);
    ticks(6);
    check("t1_wr_n_cnt", 32'(wr_cnt[0]), 32'd1);
    check("t1_wr_n_lat", 32'(wr_cyc[0] - p), 32'd1);
    check("t1_rd_node_lat", 32'(rd_cyc[4] - p), 32'd1);
    check("t1_pkt_n", pkt_out[0], 32'h3400DEAD);
    check("t1_total_wr", 32'(total_wr()), 32'd1);
    check("t1_total_rd", 32'(total_rd()), 32'd1);

    // Single-hop routing from all sources at once
    clear_logs();
    push(4, 32'h1100BEEF);
    push(1, 32'h3400CAFE);
    push(2, 32'h4300FEED);
    push(3, 32'h3200FACE);
    push(3, 32'h3300DEED);
    ticks(8);
    check("t2_w", wr_last[2], 32'h1100BEEF);
    check("t2_n", wr_last[0], 32'h3400CAFE);
    check("t2_e", wr_last[3], 32'h4300FEED);
    check("t2_s", wr_last[1], 32'h3200FACE);
    check("t2_local", wr_last[4], 32'h3300DEED);
    check("t2_local_pkt", pkt_out[4], 32'h3300DEED);
    check("t2_total_wr", 32'(total_wr()), 32'd5);
    check("t2_drop", 32'(drop_cnt), 32'd0);

    // Contention for N after reset: S wins first, Node two cycles later
    do_reset();
    clear_logs();
    p = cyc;
    push(1, 32'h3400EFAC);
    push(4, 32'h3400DAED);
    ticks(8);
    check("t3_n_cnt", 32'(wr_cnt[0]), 32'd2);
    check("t3_first", wr_first[0], 32'h3400EFAC);
    check("t3_second", wr_last[0], 32'h3400DAED);
    check("t3_first_lat", 32'(wr_first_cyc[0] - p), 32'd1);
    check("t3_gap", 32'(wr_cyc[0] - wr_first_cyc[0]), 32'd2);

    // Parallel grants to different outputs
    clear_logs();
    push(2, 32'h4300DEEF);
    push(3, 32'h3200ECAF);
    ticks(5);
    check("t4_e_cnt", 32'(wr_cnt[3]), 32'd1);
    check("t4_same_cycle", 32'(wr_cyc[3] - wr_cyc[1]), 32'd0);
    check("t4_e_data", wr_last[3], 32'h4300DEEF);
    check("t4_s_data", wr_last[1], 32'h3200ECAF);

    // Disabled N link: drop, then saturate the counter
    link_cfg = 4'b1110;
    clear_logs();
    push(4, 32'h3400DEAD);
    ticks(4);
    check("t5_rd_node", 32'(rd_cnt[4]), 32'd1);
    check("t5_no_wr", 32'(total_wr()), 32'd0);
    check("t5_drop1", 32'(drop_cnt), 32'd1);
    for (int n = 0; n < 300; n++) push(4, 32'h3400DEAD);
    for (int n = 0; n < 1000 && qmem[4].size() != 0; n++) tick();
    ticks(3);
    check("t5_drained", 32'(qmem[4].size()), 32'd0);
    check("t5_drop_sat", 32'(drop_cnt), 32'd255);
    check("t5_rd_total", 32'(rd_cnt[4]), 32'd301);
    link_cfg = 4'b1111;
    ticks(2);

    // Backpressure on N
    full[0] = 1'b1;
    clear_logs();
    push(1, 32'h3400CAFE);
    ticks(20);
    check("t6_bp_rd", 32'(rd_cnt[1]), 32'd0);
    check("t6_bp_wr", 32'(wr_cnt[0]), 32'd0);
    full[0] = 1'b0;
    p = cyc;
    ticks(4);
    check("t6_rel_lat", 32'(wr_cyc[0] - p), 32'd1);
    check("t6_rel_data", wr_last[0], 32'h3400CAFE);
    check("t6_rel_rd", 32'(rd_cyc[1] - p), 32'd1);

    // Reset during a strobe cycle
    clear_logs();
    push(4, 32'h3300ABCD);
    @(posedge Clk_r);
    #1;
    check("t6_pre_rst_wr", 32'(wr[4]), 32'd1);
    Rst = 1'b1;
    #1;
    check("t6_rst_wr", 32'(wr), 32'h0);
    check("t6_rst_rd", 32'(rd), 32'h0);
    check("t6_rst_pkt", pkt_out[4], 32'h0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    ticks(2);
    Rst = 1'b0;
    ticks(5);
    check("t6_redeliver_cnt", 32'(wr_cnt[4]), 32'd1);
    check("t6_redeliver_data", wr_last[4], 32'h3300ABCD);
    check("t6_redeliver_rd", 32'(rd_cnt[4]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_crossbar_arbiter.md
Name: router_crossbar_arbiter

Overview:
- Switch-allocation controller for one mesh router node. Sits between the five input Packet_Queues (Rx N/S/W/E and NodeToSend) and the four Tx Packet_Queues plus the local-node sink.
- Each cycle it decodes the head packet of every non-empty input using XY dimension-order routing. It arbitrates each output round-robin and drives the queue read/write strobes and packet data.
- Packets whose required link is disabled are consumed and counted as drops.

Parameters:
DROP_CNT_W, 8, width of the saturating drop counter

Ports:
Clk_r  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Router_Address  input  8  [7:4]=own X, [3:0]=own Y
Link_Config  input  4  link enable: [0]=N [1]=S [2]=W [3]=E
Packet_From_Link_N/S/W/E, Packet_From_Node  input  32 each  queue head words, valid while the matching Empty is 0
RxQueue_Empty_N/S/W/E, Node_Queue_Empty  input  1 each  input queue empty flags
TxQueue_Full_N/S/W/E  input  1 each  output queue full flags
Packet_To_Link_N/S/W/E, Packet_To_Node  output  32 each  registered packet data
TxQueue_Write_N/S/W/E, Node_Write  output  1 each  one-cycle write strobes
RxQueue_Read_N/S/W/E, Node_Read  output  1 each  one-cycle pop strobes
Drop_Count  output  DROP_CNT_W  dropped-packet count

Behaviour:
- Packet format: [31:28] destination X, [27:24] destination Y, [23:16] reserved (passed through), [15:0] payload. Packets are forwarded unmodified.
- Input indices: N=0, S=1, W=2, E=3, Node=4. Output indices: N, S, W, E, Local.
- Route decode (combinational):
  - destX > ownX -> E; destX < ownX -> W.
  - Otherwise destY > ownY -> N; destY < ownY -> S.
  - Otherwise -> Local.
  - Comparisons are unsigned 4-bit.
- Drop rule: the routed output is a link whose Link_Config bit is 0. Local is always enabled.
- Input request conditions: Empty=0 and the input is not masked.
- Output eligibility conditions:
  - Link: its Full=0 and it is not masked.
  - Local: never full; masked only.
- Arbitration:
  - One 3-bit pointer per output holds the last granted input (0..4).
  - Priority order is pointer+1, +2 … mod 5.
  - The winner is the first requesting input routed to that output.
  - The pointer updates to the winner only on a grant.
  - Each input is granted to at most one output per cycle. Its route is unique, so this holds by construction.
- Drop path: a requesting input whose route is a disabled link is granted a drop immediately. Drops need no arbitration.
- Pipeline, grant decided in cycle t, registered at edge t+1:
  - During cycle t+1: RxQueue_Read_x/Node_Read = 1 for the granted input.
  - During cycle t+1, non-drop grants only: TxQueue_Write_y/Node_Write = 1 and Packet_To_*_y = head word captured at edge t+1.
  - Both strobes are low in cycle t+2 unless a new grant occurred.
- Masking (hazard protection): for the cycle in which its strobe is high, an input with a pending Read is masked, and an output with a pending Write is masked. Peak rate per input and per output is therefore one packet every 2 cycles.
- Drop_Count increments by 1 on each drop registration. It saturates at 2^DROP_CNT_W-1 and does not wrap.
- Packet_To_* registers hold their last value when not written.
- Full sampled high at the decision cycle: no grant to that output. The input waits with no timeout.
- Link_Config changes take effect on the next decision cycle.
- Reset (Rst=1, asynchronous, any time including a pending-strobe cycle):
  - All strobes 0 and Packet_To_* = 0.
  - Drop_Count = 0, all pointers = 4, masks cleared.
  - A pending strobe is abandoned with no partial transfer.
- First decision starts in the cycle after Rst deasserts.

Test Plan:
1. Router_Address=0x33, Link_Config=4'b1111; NodeToSend gets 0x3400DEAD -> Node_Read and TxQueue_Write_N high together for exactly one cycle, 1 cycle after Node_Queue_Empty falls; Packet_To_Link_N=0x3400DEAD; no other strobes.
2. Single-hop routing from node/Rx queues:
   - Node 0x1100BEEF -> W.
   - Rx_S 0x3400CAFE -> N.
   - Rx_W 0x4300FEED -> E.
   - Rx_E 0x3200FACE -> S.
   - Rx_E 0x3300DEED -> Node_Write, Packet_To_Node=0x3300DEED.
   - Drop_Count stays 0.
3. Contention after reset: Rx_S head 0x3400EFAC and Node head 0x3400DAED both present in the same cycle -> S granted first (N pointer=4); N output masked one cycle; Node granted the following decision cycle; N output written twice, 2 cycles apart, order EFAC then DAED.
4. Parallel: Rx_W 0x4300DEEF and Rx_E 0x3200ECAF present together -> TxQueue_Write_E and TxQueue_Write_S asserted in the same cycle, with the correct data.
5. Link_Config=4'b1110, Node 0x3400DEAD -> Node_Read pulse, no TxQueue_Write_N, Drop_Count 0->1. Preload counter path with 300 drops -> Drop_Count holds at 255.
6. Backpressure and reset:
   - TxQueue_Full_N=1 with Rx_S 0x3400CAFE -> no Read/Write for 20 cycles; Full->0 -> delivered 1 cycle later.
   - Rst pulsed during a strobe cycle -> all strobes drop immediately, Drop_Count=0.
